// File: rtl/prog_loader_pkg.sv
// Shared state encoding and frame-field constants for the program loader.
// PROG_LOADER_CSUM_EN adds the trailing checksum state to the encoding.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_W_LO,
    S_W_HI,
`ifdef PROG_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned HI_DATA_BIT = 0;
  localparam logic [7:0]  HI_RSV_MASK = 8'hFE;
  localparam int unsigned MAX_COUNT   = 4095;

endpackage

// File: rtl/loader_csum.sv
// Running mod-256 sum of frame bytes, cleared per session and compared
// against the trailing checksum byte.
module loader_csum
  import prog_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_match
);

  logic [BYTE_W-1:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (r_sum == i_data);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader: parses {count, words[, checksum]} frames and writes 9-bit
// words to instruction memory. PROG_LOADER_CSUM_EN enables the checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [BYTE_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_im_wen,
  output logic [AW-1:0]     o_im_addr,
  output logic [DW-1:0]     o_im_wdat,
  output logic              o_core_hold,
  output logic              o_busy,
  output logic              o_load_done,
  output logic              o_error
);

`ifdef PROG_LOADER_CSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            r_state;
  logic [BYTE_W-1:0] r_lo;
  logic [11:0]       r_left;
  logic [AW-1:0]     r_widx;
  logic              r_in_ready, r_im_wen, r_core_hold, r_busy, r_load_done, r_error;
  logic [AW-1:0]     r_im_addr;
  logic [DW-1:0]     r_im_wdat;

  logic        w_xfer, w_start_ok, w_cnt_bad, w_hi_bad, w_csum_bad, w_fault, w_frame_end;
  logic [15:0] w_cnt16;

  assign w_xfer      = i_in_valid & r_in_ready;
  assign w_start_ok  = i_start & (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_cnt16     = {i_in_data, r_lo};
  assign w_cnt_bad   = (w_cnt16 > 16'(MAX_COUNT));
  assign w_hi_bad    = |(i_in_data & HI_RSV_MASK);
  assign w_fault     = w_xfer & (((r_state == S_CNT_HI) & w_cnt_bad) |
                                 ((r_state == S_W_HI) & w_hi_bad) | w_csum_bad);
  // Frame end means "no more words": either a zero count or the last HI byte.
  assign w_frame_end = w_xfer & (((r_state == S_CNT_HI) & (w_cnt16 == 16'd0)) |
                                 ((r_state == S_W_HI) & (r_left == 12'd1)));

`ifdef PROG_LOADER_CSUM_EN
  logic w_csum_add, w_csum_match;
  assign w_csum_add = w_xfer & (r_state != S_CSUM);
  loader_csum u_csum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_start_ok),
    .i_add   (w_csum_add),
    .i_data  (i_in_data),
    .o_match (w_csum_match)
  );
  assign w_csum_bad = (r_state == S_CSUM) & ~w_csum_match;
`else
  assign w_csum_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_left      <= '0;
      r_widx      <= '0;
      r_in_ready  <= 1'b0;
      r_im_wen    <= 1'b0;
      r_im_addr   <= '0;
      r_im_wdat   <= '0;
      r_core_hold <= 1'b1;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_im_wen <= 1'b0;
      if (w_start_ok) begin
        r_state     <= S_CNT_LO;
        r_in_ready  <= 1'b1;
        r_busy      <= 1'b1;
        r_load_done <= 1'b0;
        r_error     <= 1'b0;
        r_core_hold <= 1'b1;
        r_im_addr   <= '0;
        r_widx      <= '0;
      end else if (w_fault) begin
        r_state     <= S_ERR;
        r_in_ready  <= 1'b0;
        r_busy      <= 1'b0;
        r_error     <= 1'b1;
        r_core_hold <= 1'b1;
      end else begin
        case (r_state)
          S_CNT_LO: if (w_xfer) begin
            r_lo    <= i_in_data;
            r_state <= S_CNT_HI;
          end
          S_CNT_HI: if (w_xfer) begin
            r_left  <= w_cnt16[11:0];
            r_state <= w_frame_end ? S_END : S_W_LO;
          end
          S_W_LO: if (w_xfer) begin
            r_lo    <= i_in_data;
            r_state <= S_W_HI;
          end
          S_W_HI: if (w_xfer) begin
            r_im_wen  <= 1'b1;
            r_im_addr <= r_widx;
            r_im_wdat <= DW'({i_in_data[HI_DATA_BIT], r_lo});
            r_widx    <= r_widx + AW'(1);
            r_left    <= r_left - 12'd1;
            r_state   <= w_frame_end ? S_END : S_W_LO;
          end
`ifdef PROG_LOADER_CSUM_EN
          S_CSUM: if (w_xfer) r_state <= S_DONE;
`endif
          // One cycle after DONE is entered the final write has retired.
          S_DONE: r_core_hold <= 1'b0;
          default: ;
        endcase
`ifdef PROG_LOADER_CSUM_EN
        if (w_xfer && r_state == S_CSUM) begin
`else
        if (w_frame_end) begin
`endif
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_load_done <= 1'b1;
        end
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_im_wen    = r_im_wen;
  assign o_im_addr   = r_im_addr;
  assign o_im_wdat   = r_im_wdat;
  assign o_core_hold = r_core_hold;
  assign o_busy      = r_busy;
  assign o_load_done = r_load_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames
// compared against a frame-parsing reference model.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int AW = 12;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, im_wen, core_hold, busy, load_done, error;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdat;

  always #5 clk = ~clk;

  prog_loader #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready), .o_im_wen(im_wen),
    .o_im_addr(im_addr), .o_im_wdat(im_wdat), .o_core_hold(core_hold),
    .o_busy(busy), .o_load_done(load_done), .o_error(error)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]    tx_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_dat[$];
  bit exp_done, exp_err, timed_out;
  int sent;

  always @(negedge clk) begin
    if (rst_n && im_wen) begin
      wa_q.push_back(im_addr);
      wd_q.push_back(im_wdat);
    end
  end

  // Reference: parse the frame by its rules and list the writes it implies.
  task automatic model_frame();
    int n, p;
    logic [7:0] lo, hi, sum;
    exp_addr.delete(); exp_dat.delete();
    exp_done = 0; exp_err = 0;
    n   = int'(tx_q[0]) + 256 * int'(tx_q[1]);
    sum = tx_q[0] + tx_q[1];
    if (n > 4095) begin exp_err = 1; return; end
    p = 2;
    for (int i = 0; i < n; i++) begin
      lo = tx_q[p]; hi = tx_q[p+1]; p += 2;
      sum = sum + lo + hi;
      if ((hi & 8'hFE) != 8'h00) begin exp_err = 1; return; end
      exp_addr.push_back(AW'(i));
      exp_dat.push_back({hi[0], lo});
    end
`ifdef PROG_LOADER_CSUM_EN
    if (tx_q[p] != sum) begin exp_err = 1; return; end
`endif
    exp_done = 1;
  endtask

  task automatic add_csum(input bit bad);
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (tx_q[i]) s = s + tx_q[i];
    tx_q.push_back(bad ? s + 8'h01 : s);
`else
    if (bad) tx_q.push_back(8'h00);
`endif
  endtask

  task automatic build_frame(input int n, input int corrupt);
    int k;
    tx_q.delete();
    if (corrupt == 2) begin
      tx_q.push_back(8'($urandom));
      tx_q.push_back(8'($urandom_range(16, 255)));
      add_csum(0);
      return;
    end
    tx_q.push_back(8'(n)); tx_q.push_back(8'(n >> 8));
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'($urandom));
      if (corrupt == 1 && i == k) tx_q.push_back({7'($urandom_range(1, 127)), 1'($urandom)});
      else tx_q.push_back({7'd0, 1'($urandom)});
    end
`ifdef PROG_LOADER_CSUM_EN
    add_csum(corrupt == 3);
`endif
  endtask

  // Start a session and stream tx_q; mode 0 = valid held, 1 = toggling, 2 = random.
  task automatic run_frame(input int mode, input int max_bytes);
    int cyc;
    bit v, rdy;
    wa_q.delete(); wd_q.delete();
    sent = 0; timed_out = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (sent < tx_q.size() && sent < max_bytes && busy) begin
      if (cyc > 4000) begin timed_out = 1; break; end
      case (mode)
        0: v = 1'b1;
        1: v = ((cyc % 2) == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? tx_q[sent] : 8'($urandom);
      rdy = in_ready;
      @(negedge clk);
      if (v && rdy) sent++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, im_wen, im_addr, im_wdat, core_hold, busy, load_done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_vals rdy=%b wen=%b addr=%h wdat=%h hold=%b busy=%b done=%b err=%b expected 0 0 0 0 1 0 0 0",
               in_ready, im_wen, im_addr, im_wdat, core_hold, busy, load_done, error);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({core_hold, in_ready, im_wen, load_done} !== 4'b1000) begin
        miscompares++;
        $display("FAIL idle_cycle%0d hold/rdy/wen/done=%b expected 1000", i,
                 {core_hold, in_ready, im_wen, load_done});
      end
    end
  endtask

  task automatic test_basic(input int mode);
    tx_q = {8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h01};
    add_csum(0);
    model_frame();
    run_frame(mode, 1000);
    vectors++;
    if ({timed_out, load_done, busy, in_ready, core_hold} !== 5'b01001) begin
      miscompares++;
      $display("FAIL basic_m%0d_end to/done/busy/rdy/hold=%b expected 01001", mode,
               {timed_out, load_done, busy, in_ready, core_hold});
    end
    @(negedge clk);
    vectors++;
    if (core_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_m%0d_hold_fall got %b expected 0", mode, core_hold);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (wa_q.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL basic_m%0d_nwrites got %0d expected %0d", mode, wa_q.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < wa_q.size(); i++) begin
        vectors++;
        if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL basic_m%0d_write%0d got %h=%h expected %h=%h", mode, i,
                   wa_q[i], wd_q[i], exp_addr[i], exp_dat[i]);
        end
      end
    end
  endtask

  task automatic test_hi_fault();
    tx_q = {8'h02, 8'h00, 8'h55, 8'h02, 8'h11, 8'h00};
    add_csum(0);
    run_frame(0, 1000);
    repeat (3) @(negedge clk);
    vectors++;
    if ({error, load_done, busy, in_ready, core_hold} !== 5'b10001 || wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL hi_fault err/done/busy/rdy/hold=%b writes=%0d expected 10001 writes=0",
               {error, load_done, busy, in_ready, core_hold}, wa_q.size());
    end
    test_basic(0);
    vectors++;
    if (error !== 1'b0 || load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL recover_after_err err=%b done=%b expected 0 1", error, load_done);
    end
  endtask

  task automatic test_count_edges();
    tx_q = {8'h00, 8'h10};
    run_frame(0, 1000);
    repeat (3) @(negedge clk);
    vectors++;
    if ({error, load_done, core_hold} !== 3'b101 || wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL count_4096 err/done/hold=%b writes=%0d expected 101 writes=0",
               {error, load_done, core_hold}, wa_q.size());
    end
    tx_q = {8'h00, 8'h00};
    add_csum(0);
    run_frame(0, 1000);
    repeat (3) @(negedge clk);
    vectors++;
    if ({error, load_done, busy, core_hold} !== 4'b0100 || wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL count_zero err/done/busy/hold=%b writes=%0d expected 0100 writes=0",
               {error, load_done, busy, core_hold}, wa_q.size());
    end
  endtask

  task automatic test_random();
    int corrupt;
    for (int f = 0; f < 12; f++) begin
      corrupt = $urandom_range(0, 3);
`ifndef PROG_LOADER_CSUM_EN
      if (corrupt == 3) corrupt = 0;
`endif
      build_frame($urandom_range(1, 6), corrupt);
      model_frame();
      run_frame(2, 1000);
      repeat (3) @(negedge clk);
      vectors++;
      if ({timed_out, load_done, error, busy, in_ready, core_hold} !==
          {1'b0, exp_done, exp_err, 1'b0, 1'b0, exp_err}) begin
        miscompares++;
        $display("FAIL rand%0d to/done/err/busy/rdy/hold=%b expected %b", f,
                 {timed_out, load_done, error, busy, in_ready, core_hold},
                 {1'b0, exp_done, exp_err, 1'b0, 1'b0, exp_err});
      end
      vectors++;
      if (wa_q.size() != exp_addr.size()) begin
        miscompares++;
        $display("FAIL rand%0d_nwrites got %0d expected %0d", f, wa_q.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < wa_q.size(); i++) begin
          vectors++;
          if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_dat[i]) begin
            miscompares++;
            $display("FAIL rand%0d_write%0d got %h=%h expected %h=%h", f, i,
                     wa_q[i], wd_q[i], exp_addr[i], exp_dat[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midsession();
    build_frame(8, 0);
    model_frame();
    run_frame(2, 13);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, im_wen, im_addr, im_wdat, core_hold, busy, load_done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_vals rdy=%b wen=%b addr=%h wdat=%h hold=%b busy=%b done=%b err=%b expected 0 0 0 0 1 0 0 0",
               in_ready, im_wen, im_addr, im_wdat, core_hold, busy, load_done, error);
    end
    vectors++;
    if (wa_q.size() != 5) begin
      miscompares++;
      $display("FAIL midreset_nwrites got %0d expected 5", wa_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL midreset_write%0d got %h=%h expected %h=%h", i,
                   wa_q[i], wd_q[i], exp_addr[i], exp_dat[i]);
        end
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, busy, core_hold, im_wen} !== 4'b0010) begin
      miscompares++;
      $display("FAIL midreset_idle rdy/busy/hold/wen=%b expected 0010", {in_ready, busy, core_hold, im_wen});
    end
  endtask

`ifdef PROG_LOADER_CSUM_EN
  task automatic test_bad_csum();
    tx_q = {8'h01, 8'h00, 8'hAA, 8'h01};
    add_csum(1);
    run_frame(0, 1000);
    repeat (3) @(negedge clk);
    vectors++;
    if (wa_q.size() != 1 || {error, load_done, core_hold} !== 3'b101) begin
      miscompares++;
      $display("FAIL bad_csum writes=%0d err/done/hold=%b expected writes=1 101",
               wa_q.size(), {error, load_done, core_hold});
    end else begin
      vectors++;
      if (wa_q[0] !== 12'h000 || wd_q[0] !== 9'h1AA) begin
        miscompares++;
        $display("FAIL bad_csum_write got %h=%h expected 000=1aa", wa_q[0], wd_q[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_hi_fault();
    test_count_edges();
    test_random();
    test_reset_midsession();
`ifdef PROG_LOADER_CSUM_EN
    test_bad_csum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
